// File: rtl/pc_gen_pkg.sv
// Shared encodings and helpers for the fetch-stage PC generator.
// D-stage jump classes mirror the BR_* values long used by the single-cycle core.
package pc_gen_pkg;

  localparam logic [2:0] BR_pc4 = 3'd0;
  localparam logic [2:0] BR_j   = 3'd1;
  localparam logic [2:0] BR_jr  = 3'd2;
  localparam logic [2:0] BR_br  = 3'd3;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BYTES = 32'h0000_4000;

  // Sign-extended word offset of a conditional branch, as a 32-bit byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_npc_sel.sv
// Redirect target selection for the instruction in D (J/JAL, JR/JALR, branch).
// Purely combinational; the delay slot is the instruction fetched alongside.
module pc_gen_npc_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [2:0]        br_sel,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] pc4,
  output logic [ADDR_W-1:0] target_c
);

  logic [31:0]       d_pc32;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] br_target;

  // Widen first so the region bits stay well-defined for any ADDR_W in 28..32.
  assign d_pc32    = 32'(d_pc);
  assign j_target  = ADDR_W'({d_pc32[31:28], imm26, 2'b00});
  assign br_target = d_pc + ADDR_W'(4) + ADDR_W'(branch_offset(imm26[15:0]));

  always_comb begin
    target_c = pc4;
    case (br_sel)
      BR_pc4:  target_c = pc4;
      BR_j:    target_c = j_target;
      BR_jr:   target_c = rs_val;
      BR_br:   target_c = br_taken ? br_target : pc4;
      default: target_c = pc4;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register with exception/ERET/stall priority and fetch
// address-error detection against the instruction-memory window.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter logic [31:0] IM_BYTES = DEF_IM_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        br_sel,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              exc_req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  output logic [ADDR_W-1:0] npc,
  output logic              pc_adel
);

  localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] EXC_VAL = ADDR_W'(EXC_PC);
  // One extra bit so a window ending at 2^32 does not wrap.
  localparam logic [32:0] IM_LO = 33'(IM_BASE);
  localparam logic [32:0] IM_HI = 33'(IM_BASE) + 33'(IM_BYTES);

  logic [ADDR_W-1:0] redirect;
  logic [32:0]       pc_ext;

  assign pc4 = pc + ADDR_W'(4);

  pc_gen_npc_sel #(.ADDR_W(ADDR_W)) u_npc_sel (
    .br_sel   (br_sel),
    .br_taken (br_taken),
    .d_pc     (d_pc),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .pc4      (pc4),
    .target_c (redirect)
  );

  // Priority: reset > exception > eret > stall > redirect.
  always_comb begin
    npc = redirect;
    if (reset)        npc = RST_VAL;
    else if (exc_req) npc = EXC_VAL;
    else if (eret)    npc = epc;
    else if (stall)   npc = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RST_VAL;
    else       pc <= npc;
  end

  assign pc_ext  = 33'(pc);
  assign pc_adel = (pc[1:0] != 2'b00) || (pc_ext < IM_LO) || (pc_ext >= IM_HI);

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against an arithmetic reference model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, exc_req, eret;
  logic [2:0]  br_sel;
  logic [31:0] d_pc, rs_val, epc;
  logic [25:0] imm26;
  logic [31:0] pc, pc4, npc;
  logic        pc_adel;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .br_sel(br_sel), .br_taken(br_taken),
    .d_pc(d_pc), .imm26(imm26), .rs_val(rs_val), .exc_req(exc_req), .eret(eret),
    .epc(epc), .pc(pc), .pc4(pc4), .npc(npc), .pc_adel(pc_adel)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] cur);
    longint off;
    if (reset)   return 32'h0000_3000;
    if (exc_req) return 32'h0000_4180;
    if (eret)    return epc;
    if (stall)   return cur;
    case (br_sel)
      3'd1: return (d_pc & 32'hF000_0000) | (32'(imm26) * 4);
      3'd2: return rs_val;
      3'd3: begin
        if (!br_taken) return cur + 32'd4;
        off = longint'($signed(imm26[15:0])) * 4;
        return 32'(longint'(d_pc) + 4 + off);
      end
      default: return cur + 32'd4;
    endcase
  endfunction

  function automatic logic ref_adel(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000) || (p >= 32'h7000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Apply inputs, check npc, clock once, then check the registered results.
  task automatic step(input logic rst, input logic stl, input logic [2:0] sel,
                      input logic tk, input logic [31:0] dp, input logic [25:0] im,
                      input logic [31:0] rs, input logic exc, input logic er,
                      input logic [31:0] ep, input string tag);
    logic [31:0] nxt;
    reset = rst; stall = stl; br_sel = sel; br_taken = tk; d_pc = dp; imm26 = im;
    rs_val = rs; exc_req = exc; eret = er; epc = ep;
    nxt = ref_next(exp_pc);
    #1;
    chk({tag, ".npc"}, npc, nxt);
    @(posedge clk); #1;
    exp_pc = nxt;
    chk({tag, ".pc"}, pc, exp_pc);
    chk({tag, ".pc4"}, pc4, exp_pc + 32'd4);
    chk({tag, ".adel"}, 32'(pc_adel), 32'(ref_adel(exp_pc)));
  endtask

  initial begin
    exp_pc = 32'hx;
    @(negedge clk);
    step(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    step(1, 1, 3'd2, 1, 0, 0, 32'h5, 1, 1, 32'h9, "rst1_exc");
    chk("rst_pc_const", pc, 32'h3000);
    step(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, "seq1");
    step(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, "seq2");
    step(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, "seq3");
    chk("seq_pc_const", pc, 32'h300C);
    step(0, 0, 3'd3, 1, 32'h3010, 26'h000FFFC, 0, 0, 0, 0, "br_taken");
    chk("br_taken_const", pc, 32'h3004);
    step(0, 0, 3'd3, 0, 32'h3010, 26'h000FFFC, 0, 0, 0, 0, "br_not");
    chk("br_not_const", pc, 32'h3008);
    step(0, 0, 3'd1, 0, 32'h3020, 26'h0000C40, 0, 0, 0, 0, "j");
    chk("j_const", pc, 32'h3100);
    step(0, 0, 3'd2, 0, 0, 0, 32'h3002, 0, 0, 0, "jr_mis");
    chk("jr_adel_const", 32'(pc_adel), 32'd1);
    for (int i = 0; i < 3; i++)
      step(0, 1, 3'd3, 1, 32'h3010, 26'h0000040, 0, 0, 0, 0, "stall");
    chk("stall_const", pc, 32'h3002);
    step(0, 1, 3'd0, 0, 0, 0, 0, 1, 0, 0, "stall_exc");
    chk("stall_exc_const", pc, 32'h4180);
    step(0, 0, 3'd0, 0, 0, 0, 0, 1, 1, 32'h3040, "exc_eret");
    chk("exc_eret_const", pc, 32'h4180);
    step(0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3040, "eret");
    chk("eret_const", pc, 32'h3040);
    step(0, 0, 3'd2, 0, 0, 0, 32'h6FFC, 0, 0, 0, "to_top");
    step(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, "past_top");
    chk("past_top_adel", 32'(pc_adel), 32'd1);
    step(0, 0, 3'd2, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, "to_max");
    step(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, "wrap");
    chk("wrap_const", pc, 32'h0);
    step(0, 0, 3'd7, 0, 0, 0, 0, 0, 0, 0, "unused_sel");
    step(1, 1, 3'd1, 0, 0, 0, 0, 1, 0, 0, "rst_exc");
    chk("rst_exc_const", pc, 32'h3000);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      step(r[7:0] == 0, r[10:8] == 0, 3'($urandom_range(0, 7)), r[11],
           32'h3000 + ($urandom & 32'h3FFC) | (r[12] ? 32'hA000_0000 : 32'h0),
           26'($urandom), r[13] ? 32'h3000 + ($urandom & 32'h3FFF) : $urandom,
           r[18:15] == 0, r[22:19] == 0, 32'h3000 + ($urandom & 32'h3FFC), "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
